pixel_plot_sink: RTL and testbench

PIXEL_PLOT_SINK -- requirements
Module: pixel_plot_sink

---
 rtl/pixel_plot_sink.sv | 245 ++++++++++++++++++++++++
 tb/tb_pixel_plot_sink.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink
// Buffers pixel writes from a drawing engine in a small FIFO and streams them
// to a frame memory, one write per cycle when the memory is ready. It can also
// fill the whole screen with BG_COLOUR on request. Pixels outside the screen
// are discarded and counted.
//
// Ports
//   clk         system clock, all state on the rising edge
//   resetn      asynchronous active-low reset
//   in_valid    pixel write request            in_ready  sink accepts this cycle
//   in_x/in_y   pixel coordinates (8 bits)     in_colour 9-bit colour (3/3/3)
//   clear_req   single-cycle request for a screen clear
//   mem_ready   frame memory accepts a write this cycle
//   plot        registered write strobe; vga_x/vga_y/vga_colour registered write data
//   busy        FIFO non-empty, clear pending, or clear running
//   clear_done  one-cycle pulse after the last clear write
//   drop_count  saturating count of discarded off-screen pixels
module pixel_plot_sink #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         X_MAX      = 160,
  parameter int         Y_MAX      = 120,
  parameter logic [8:0] BG_COLOUR  = 9'h000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  input  logic [8:0] in_colour,
  output logic       in_ready,
  input  logic       clear_req,
  input  logic       mem_ready,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [8:0] vga_colour,
  output logic       busy,
  output logic       clear_done,
  output logic [7:0] drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  // 9-bit limits so a screen width of 256 still compares correctly
  localparam logic [8:0]    X_LIM    = 9'(X_MAX);
  localparam logic [8:0]    Y_LIM    = 9'(Y_MAX);
  localparam logic [7:0]    X_LAST   = 8'(X_MAX - 1);
  localparam logic [7:0]    Y_LAST   = 8'(Y_MAX - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [24:0]     fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            pending_r;
  logic [7:0]      cx_r;
  logic [7:0]      cy_r;
  logic [24:0]     head_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            in_range_s;
  logic            accept_s;
  logic            push_s;
  logic            drop_s;
  logic            pop_s;
  logic            clr_write_s;
  logic            clr_last_s;

  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign fifo_full_s  = (count_r == DEPTH_C);
  assign head_s       = fifo_mem_r[rd_ptr_r];

  // resetn is folded in because state_r already reads RUN while reset is held
  assign in_ready   = resetn & (state_r == ST_RUN) & ~fifo_full_s & ~pending_r;
  assign in_range_s = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);
  assign accept_s   = in_valid & in_ready;
  assign push_s     = accept_s & in_range_s;
  assign drop_s     = accept_s & ~in_range_s;
  assign busy       = ~fifo_empty_s | pending_r | (state_r == ST_CLEAR);

  // Next-state logic and per-cycle write decisions
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    clr_write_s = 1'b0;
    clr_last_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (!fifo_empty_s && mem_ready) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
        // queued pixels always drain before the clear starts
        if (pending_r && fifo_empty_s) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_CLEAR: begin
        if (mem_ready) begin
          clr_write_s = 1'b1;
          if ((cx_r == X_LAST) && (cy_r == Y_LAST)) begin
            clr_last_s  = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            clr_last_s  = 1'b0;
            state_nxt_s = ST_CLEAR;
          end
        end else begin
          clr_write_s = 1'b0;
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Clear-pending flag; requests while pending or clearing are ignored
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_r <= 1'b0;
    end else if (clr_last_s) begin
      pending_r <= 1'b0;
    end else if (clear_req && !pending_r) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Clear raster position, row-major
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx_r <= 8'd0;
      cy_r <= 8'd0;
    end else if (state_r == ST_RUN) begin
      if (state_nxt_s == ST_CLEAR) begin
        cx_r <= 8'd0;
        cy_r <= 8'd0;
      end else begin
        cx_r <= cx_r;
        cy_r <= cy_r;
      end
    end else if (clr_write_s) begin
      if (cx_r == X_LAST) begin
        cx_r <= 8'd0;
        cy_r <= cy_r + 8'd1;
      end else begin
        cx_r <= cx_r + 8'd1;
        cy_r <= cy_r;
      end
    end else begin
      cx_r <= cx_r;
      cy_r <= cy_r;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {in_x, in_y, in_colour};
    end
  end

  // FIFO pointers and occupancy; push and pop may share an edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered frame-memory write port and clear completion pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot       <= 1'b0;
      vga_x      <= 8'd0;
      vga_y      <= 8'd0;
      vga_colour <= 9'd0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= clr_last_s;
      if (pop_s) begin
        plot       <= 1'b1;
        vga_x      <= head_s[24:17];
        vga_y      <= head_s[16:9];
        vga_colour <= head_s[8:0];
      end else if (clr_write_s) begin
        plot       <= 1'b1;
        vga_x      <= cx_r;
        vga_y      <= cy_r;
        vga_colour <= BG_COLOUR;
      end else begin
        plot <= 1'b0;
      end
    end
  end

  // Saturating count of discarded off-screen pixels
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_count <= 8'd0;
    end else if (drop_s && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end else begin
      drop_count <= drop_count;
    end
  end

endmodule

// File: tb/tb_pixel_plot_sink.sv
module tb_pixel_plot_sink;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_x = 8'd0;
  logic [7:0] in_y = 8'd0;
  logic [8:0] in_colour = 9'd0;
  logic       in_ready;
  logic       clear_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic       plot;
  logic [7:0] vga_x;
  logic [7:0] vga_y;
  logic [8:0] vga_colour;
  logic       busy;
  logic       clear_done;
  logic [7:0] drop_count;

  int n_vec = 0;
  int n_bad = 0;

  pixel_plot_sink dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_colour(in_colour), .in_ready(in_ready), .clear_req(clear_req),
    .mem_ready(mem_ready), .plot(plot), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .busy(busy), .clear_done(clear_done),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] c;
    logic       mr;
    logic       rdy;
    logic       pl;
    logic [7:0] ex;
    logic [7:0] ey;
    logic [8:0] ec;
    logic [7:0] drop;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(logic v, logic [7:0] x, logic [7:0] y, logic [8:0] c, logic mr,
                              logic rdy, logic pl, logic [7:0] ex, logic [7:0] ey,
                              logic [8:0] ec, logic [7:0] drop);
    vec_t t;
    t.v = v; t.x = x; t.y = y; t.c = c; t.mr = mr;
    t.rdy = rdy; t.pl = pl; t.ex = ex; t.ey = ey; t.ec = ec; t.drop = drop;
    return t;
  endfunction

  initial begin
    int idx;
    int cyc;
    int k;
    logic mr_prev;

    //          v     x      y      c       mr    rdy   pl    ex     ey     ec      drop
    tbl[0]  = mk(1'b1, 8'd10, 8'd20, 9'h1C0, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0,  9'h000, 8'd0);
    tbl[1]  = mk(1'b0, 8'd0,  8'd0,  9'h000, 1'b1, 1'b1, 1'b1, 8'd10, 8'd20, 9'h1C0, 8'd0);
    tbl[2]  = mk(1'b1, 8'd160,8'd0,  9'h1FF, 1'b1, 1'b1, 1'b0, 8'd10, 8'd20, 9'h1C0, 8'd1);
    tbl[3]  = mk(1'b1, 8'd0,  8'd120,9'h055, 1'b1, 1'b1, 1'b0, 8'd10, 8'd20, 9'h1C0, 8'd2);
    tbl[4]  = mk(1'b1, 8'd159,8'd119,9'h00F, 1'b0, 1'b1, 1'b0, 8'd10, 8'd20, 9'h1C0, 8'd2);
    tbl[5]  = mk(1'b1, 8'd0,  8'd0,  9'h0F0, 1'b0, 1'b1, 1'b0, 8'd10, 8'd20, 9'h1C0, 8'd2);
    tbl[6]  = mk(1'b1, 8'd1,  8'd2,  9'h111, 1'b0, 1'b1, 1'b0, 8'd10, 8'd20, 9'h1C0, 8'd2);
    tbl[7]  = mk(1'b1, 8'd3,  8'd4,  9'h122, 1'b0, 1'b1, 1'b0, 8'd10, 8'd20, 9'h1C0, 8'd2);
    tbl[8]  = mk(1'b1, 8'd5,  8'd6,  9'h133, 1'b0, 1'b0, 1'b0, 8'd10, 8'd20, 9'h1C0, 8'd2);
    tbl[9]  = mk(1'b1, 8'd5,  8'd6,  9'h133, 1'b1, 1'b0, 1'b1, 8'd159,8'd119,9'h00F, 8'd2);
    tbl[10] = mk(1'b1, 8'd5,  8'd6,  9'h133, 1'b1, 1'b1, 1'b1, 8'd0,  8'd0,  9'h0F0, 8'd2);
    tbl[11] = mk(1'b0, 8'd0,  8'd0,  9'h000, 1'b1, 1'b1, 1'b1, 8'd1,  8'd2,  9'h111, 8'd2);
    tbl[12] = mk(1'b0, 8'd0,  8'd0,  9'h000, 1'b1, 1'b1, 1'b1, 8'd3,  8'd4,  9'h122, 8'd2);
    tbl[13] = mk(1'b0, 8'd0,  8'd0,  9'h000, 1'b1, 1'b1, 1'b1, 8'd5,  8'd6,  9'h133, 8'd2);
    tbl[14] = mk(1'b0, 8'd0,  8'd0,  9'h000, 1'b1, 1'b1, 1'b0, 8'd5,  8'd6,  9'h133, 8'd2);

    // reset state, with a request present to show in_ready stays low
    in_valid = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_vga_x", 32'(vga_x), 32'd0);
    chk("rst_vga_colour", 32'(vga_colour), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // table-driven single pixel, clipping, backpressure and push+pop
    for (int i = 0; i < 15; i++) begin
      in_valid  = tbl[i].v;
      in_x      = tbl[i].x;
      in_y      = tbl[i].y;
      in_colour = tbl[i].c;
      mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("v%0d_plot", i), 32'(plot), 32'(tbl[i].pl));
      chk($sformatf("v%0d_vga", i), {7'd0, vga_x, vga_y, vga_colour},
          {7'd0, tbl[i].ex, tbl[i].ey, tbl[i].ec});
      chk($sformatf("v%0d_drop", i), 32'(drop_count), 32'(tbl[i].drop));
    end
    in_valid = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);

    // drop counter saturation: 300 off-screen pixels
    in_valid = 1'b1;
    in_x = 8'd200;
    in_y = 8'd5;
    in_colour = 9'h1FF;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (plot) k++;
    end
    in_valid = 1'b0;
    chk("sat_drop", 32'(drop_count), 32'd255);
    chk("sat_no_plot", 32'(k), 32'd0);

    // clear with two queued pixels, stalls and an ignored second request
    mem_ready = 1'b0;
    in_valid = 1'b1;
    in_x = 8'd7; in_y = 8'd8; in_colour = 9'h0AA;
    tick();
    in_x = 8'd9; in_y = 8'd10; in_colour = 9'h0BB;
    tick();
    in_valid = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_pending_ready", 32'(in_ready), 32'd0);
    chk("clr_pending_busy", 32'(busy), 32'd1);
    // offer a pixel throughout the clear; it must never be taken
    in_valid = 1'b1;
    in_x = 8'd1; in_y = 8'd1; in_colour = 9'h1FF;
    idx = 0;
    cyc = 0;
    while (idx < 19202 && cyc < 30000) begin
      mem_ready = ((cyc % 5) != 2);
      clear_req = (cyc == 1000);
      mr_prev = mem_ready;
      tick();
      cyc++;
      if (plot) begin
        logic [7:0] ex;
        logic [7:0] ey;
        logic [8:0] ec;
        if (idx == 0) begin
          ex = 8'd7; ey = 8'd8; ec = 9'h0AA;
        end else if (idx == 1) begin
          ex = 8'd9; ey = 8'd10; ec = 9'h0BB;
        end else begin
          k = idx - 2;
          ex = 8'(k % 160); ey = 8'(k / 160); ec = 9'h000;
        end
        chk($sformatf("clr_write%0d", idx), {7'd0, vga_x, vga_y, vga_colour},
            {7'd0, ex, ey, ec});
        chk("clr_plot_needs_mem_ready", 32'(mr_prev), 32'd1);
        chk($sformatf("clr_done_at%0d", idx), 32'(clear_done), 32'(idx == 19201));
        idx++;
      end else if (clear_done) begin
        chk("clr_done_without_write", 32'(clear_done), 32'd0);
      end
    end
    in_valid = 1'b0;
    clear_req = 1'b0;
    chk("clr_write_count", 32'(idx), 32'd19202);
    chk("clr_ready_back", 32'(in_ready), 32'd1);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (plot || clear_done) k++;
    end
    chk("clr_quiet_after", 32'(k), 32'd0);
    chk("clr_busy_after", 32'(busy), 32'd0);

    // reset in the middle of a clear at write 5000
    mem_ready = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 5000 && cyc < 6000) begin
      tick();
      cyc++;
      if (plot) idx++;
    end
    chk("mid_write_count", 32'(idx), 32'd5000);
    chk("mid_last_xy", {16'd0, vga_x, vga_y}, {16'd0, 8'd39, 8'd31});
    resetn = 1'b0;
    #1;
    chk("mid_rst_plot", 32'(plot), 32'd0);
    chk("mid_rst_done", 32'(clear_done), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    tick();
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (plot || clear_done) k++;
    end
    chk("post_rst_quiet", 32'(k), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
